// File: rtl/wave_capture_buf.sv
// Triggered multi-channel capture buffer: pre/post-trigger frames with decimation and auto/normal/single modes.
// Optional build macro PEAK_DET_EN: store per-channel peak over each decimation window instead of the first sample.
module wave_capture_buf #(
    parameter int CH_NUM   = 2,
    parameter int CH_W     = 1,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 640,
    parameter int ADDR_W   = 10,
    parameter int PRE_TRIG = 320,
    parameter int DECIM_W  = 8,
    parameter int AUTO_TO  = 1024
) (
    input  logic                     sys_clk,
    input  logic                     areset,
    input  logic                     smp_valid,
    input  logic [CH_NUM*DATA_W-1:0] smp_data,
    input  logic [DECIM_W-1:0]       decim,
    input  logic [CH_W-1:0]          trig_ch,
    input  logic [DATA_W-1:0]        trig_level,
    input  logic                     trig_edge,
    input  logic [1:0]               trig_mode,
    input  logic                     arm,
    input  logic                     frame_ack,
    input  logic [CH_W-1:0]          rd_ch,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     frame_rdy,
    output logic                     trig_seen,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int CNT_W = $clog2((AUTO_TO > DEPTH ? AUTO_TO : DEPTH) + 1);
    localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_TRIG - 1);
    localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(DEPTH - PRE_TRIG - 1);
    localparam logic [CNT_W-1:0]  AUTO_LAST = CNT_W'(AUTO_TO - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   PRE_X     = (ADDR_W+1)'(PRE_TRIG);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      trig_ptr_q, trig_ptr_d;
    logic [DECIM_W-1:0]     dcnt_q, dcnt_d;
    logic [DECIM_W-1:0]     decim_q, decim_d;
    logic [1:0]             mode_q, mode_d;
    logic [DATA_W-1:0]      prv_q, prv_d;
    logic                   prv_vld_q, prv_vld_d;
    logic                   trig_seen_q, trig_seen_d;

    logic [CH_NUM-1:0][DATA_W-1:0] cur_smp, store_val;
    logic [CH_W-1:0]        trig_sel;
    logic [DATA_W-1:0]      trig_cur;
    logic                   capturing, accept, edge_hit, start_cap;

`ifdef PEAK_DET_EN
    logic [CH_NUM-1:0][DATA_W-1:0] acc_q, acc_d;
`endif

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        assign cur_smp[c] = smp_data[c*DATA_W +: DATA_W];
`ifdef PEAK_DET_EN
        assign store_val[c] = (acc_q[c] > cur_smp[c]) ? acc_q[c] : cur_smp[c];
`else
        assign store_val[c] = cur_smp[c];
`endif
    end

    assign trig_sel  = (int'(trig_ch) >= CH_NUM) ? '0 : trig_ch;
    assign trig_cur  = store_val[trig_sel];
    assign capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    assign accept    = smp_valid && (dcnt_q == '0) && capturing;
    assign start_cap = (state_q == S_IDLE) && (!trig_mode[1] || arm);
    assign edge_hit  = prv_vld_q && (trig_edge ? (prv_q > trig_level && trig_cur <= trig_level)
                                               : (prv_q < trig_level && trig_cur >= trig_level));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        trig_ptr_d  = trig_ptr_q;
        dcnt_d      = dcnt_q;
        decim_d     = decim_q;
        mode_d      = mode_q;
        prv_d       = prv_q;
        prv_vld_d   = prv_vld_q;
        trig_seen_d = trig_seen_q;

        if (smp_valid)
            dcnt_d = (dcnt_q == '0) ? decim_q : dcnt_q - 1'b1;
        if (accept) begin
            wr_ptr_d  = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            prv_d     = trig_cur;
            prv_vld_d = 1'b1;
        end

        case (state_q)
            S_IDLE: if (start_cap) begin
                state_d   = S_PRE;
                mode_d    = trig_mode;
                decim_d   = decim;
                wr_ptr_d  = '0;
                cnt_d     = '0;
                dcnt_d    = '0;
                prv_vld_d = 1'b0;
            end
            S_PRE: if (accept) begin
                if (cnt_q == PRE_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: if (accept) begin
                // the trigger sample itself is the first of the post-trigger samples
                if (edge_hit || (mode_q == 2'b00 && cnt_q == AUTO_LAST)) begin
                    state_d     = S_POST;
                    trig_ptr_d  = wr_ptr_q;
                    trig_seen_d = edge_hit;
                    cnt_d       = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_POST: if (accept) begin
                if (cnt_q == POST_LAST) state_d = S_DONE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            S_DONE: if (frame_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge areset) begin
        if (areset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            trig_ptr_q  <= '0;
            dcnt_q      <= '0;
            decim_q     <= '0;
            mode_q      <= '0;
            prv_q       <= '0;
            prv_vld_q   <= 1'b0;
            trig_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            trig_ptr_q  <= trig_ptr_d;
            dcnt_q      <= dcnt_d;
            decim_q     <= decim_d;
            mode_q      <= mode_d;
            prv_q       <= prv_d;
            prv_vld_q   <= prv_vld_d;
            trig_seen_q <= trig_seen_d;
        end
    end

`ifdef PEAK_DET_EN
    // window max restarts at every store and at capture start
    always_comb begin
        acc_d = acc_q;
        if (start_cap) begin
            acc_d = '0;
        end else if (smp_valid && capturing) begin
            for (int c = 0; c < CH_NUM; c++)
                acc_d[c] = accept ? '0 : store_val[c];
        end
    end

    always_ff @(posedge sys_clk or posedge areset) begin
        if (areset) acc_q <= '0;
        else        acc_q <= acc_d;
    end
`endif

    // Read side: rotate display column so column 0 is the oldest pre-trigger sample
    logic [DATA_W-1:0] mem [CH_NUM][DEPTH];
    logic [ADDR_W:0]   start_x, sum_x;
    logic [ADDR_W-1:0] phys;
    logic [CH_W-1:0]   rd_sel;
    logic              rd_ok;
    logic              rd_ok_q;
    logic [DATA_W-1:0] ram_q;

    assign start_x = ({1'b0, trig_ptr_q} >= PRE_X) ? {1'b0, trig_ptr_q} - PRE_X
                                                   : {1'b0, trig_ptr_q} + DEPTH_X - PRE_X;
    assign sum_x   = start_x + {1'b0, rd_addr};
    assign rd_ok   = (int'(rd_addr) < DEPTH) && (int'(rd_ch) < CH_NUM);
    assign phys    = !rd_ok ? '0 : (sum_x >= DEPTH_X) ? ADDR_W'(sum_x - DEPTH_X) : ADDR_W'(sum_x);
    assign rd_sel  = rd_ok ? rd_ch : '0;

    always_ff @(posedge sys_clk) begin
        if (accept)
            for (int c = 0; c < CH_NUM; c++)
                mem[c][wr_ptr_q] <= store_val[c];
        ram_q <= mem[rd_sel][phys];
    end

    always_ff @(posedge sys_clk or posedge areset) begin
        if (areset) rd_ok_q <= 1'b0;
        else        rd_ok_q <= rd_ok;
    end

    assign rd_data   = rd_ok_q ? ram_q : '0;
    assign frame_rdy = (state_q == S_DONE);
    assign trig_seen = trig_seen_q;
    assign state     = state_q;

endmodule
